// File: rtl/imem_port_arbiter.sv
// Arbitrates a single-port synchronous instruction memory between instruction fetch and a
// boot/debug loader, stalling fetch and injecting NOPs while the loader owns the memory.
module imem_port_arbiter #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned MAX_BURST = 64,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  fetch_addr,
  output logic [31:0]                  fetch_data,
  output logic                         fetch_stall,
  output logic                         fetch_misalign,
  input  logic                         ldr_req,
  input  logic                         ldr_valid,
  input  logic [31:0]                  ldr_addr,
  input  logic [31:0]                  ldr_wdata,
  output logic                         ldr_gnt,
  output logic                         ldr_err,
  output logic [15:0]                  ldr_count,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
  output logic [31:0]                  mem_wdata,
  input  logic [31:0]                  mem_rdata
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {StFetch, StDrain, StLoader, StResume} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [15:0]     count_q, count_d;
  logic            err_q, err_d;
  logic            rd_valid_q;
  logic            post_rst_q;
  logic            misalign_q;
  logic            in_range;

  assign in_range = (ldr_addr[31:2+AW] == '0);

  always_comb begin
    state_d   = state_q;
    burst_d   = burst_q;
    count_d   = count_q;
    err_d     = err_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = fetch_addr[2+:AW];
    mem_wdata = ldr_wdata;
    unique case (state_q)
      StFetch: begin
        mem_en = 1'b1;
        // Any FETCH cycle satisfies the one-cycle fetch window, so a new grant starts fresh.
        if (ldr_req) begin
          state_d = StDrain;
          burst_d = '0;
        end
      end
      StDrain: state_d = StLoader;
      StLoader: begin
        mem_addr = ldr_addr[2+:AW];
        if (ldr_valid) begin
          if (in_range) begin
            mem_en  = 1'b1;
            mem_we  = 1'b1;
            burst_d = burst_q + 1'b1;
            if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
          end else begin
            err_d = 1'b1;
          end
        end
        if (!ldr_req || burst_d == BW'(MAX_BURST)) state_d = StResume;
      end
      StResume: begin
        mem_en = 1'b1;
        if (!ldr_req) burst_d = '0;
        state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
    // An abandoned burst must not write while reset is being applied.
    if (reset) begin
      mem_en = 1'b0;
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StFetch;
      burst_q    <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      post_rst_q <= 1'b1;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
      count_q    <= count_d;
      err_q      <= err_d;
      rd_valid_q <= (state_q == StFetch) || (state_q == StResume);
      post_rst_q <= 1'b0;
      misalign_q <= (state_q == StFetch) && (fetch_addr[1:0] != 2'b00);
    end
  end

  assign fetch_data     = rd_valid_q ? mem_rdata : NOP_INSTR;
  assign fetch_stall    = post_rst_q || (state_q != StFetch);
  assign fetch_misalign = misalign_q;
  assign ldr_gnt        = (state_q == StLoader);
  assign ldr_err        = err_q;
  assign ldr_count      = count_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a behavioural synchronous RAM behind the memory port.
module tb_imem_port_arbiter;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_data;
  logic        fetch_stall;
  logic        fetch_misalign;
  logic        ldr_req;
  logic        ldr_valid;
  logic [31:0] ldr_addr;
  logic [31:0] ldr_wdata;
  logic        ldr_gnt;
  logic        ldr_err;
  logic [15:0] ldr_count;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] ram [0:1023];
  logic        ram_init;
  int          n_total = 0;
  int          n_bad = 0;

  imem_port_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_addr    (fetch_addr),
    .fetch_data    (fetch_data),
    .fetch_stall   (fetch_stall),
    .fetch_misalign(fetch_misalign),
    .ldr_req       (ldr_req),
    .ldr_valid     (ldr_valid),
    .ldr_addr      (ldr_addr),
    .ldr_wdata     (ldr_wdata),
    .ldr_gnt       (ldr_gnt),
    .ldr_err       (ldr_err),
    .ldr_count     (ldr_count),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  // Word i initially holds 0xA000_0000 | i.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'hA000_0000 | i;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int k);
    ldr_addr  = 32'h100 + 32'(k) * 4;
    ldr_wdata = 32'h5000_0000 + 32'(k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; ram_init = 1'b1; fetch_addr = 0;
    ldr_req = 0; ldr_valid = 0; ldr_addr = 0; ldr_wdata = 0;
    tick(); tick(); tick();

    // Post-reset stall cycle.
    reset = 1'b0; ram_init = 1'b0; fetch_addr = 32'h0;
    #1;
    check_eq("rst_stall", 32'(fetch_stall), 1);
    check_eq("rst_data", fetch_data, NOP);
    check_eq("rst_gnt", 32'(ldr_gnt), 0);
    check_eq("rst_err", 32'(ldr_err), 0);
    check_eq("rst_count", 32'(ldr_count), 0);
    check_eq("rst_misalign", 32'(fetch_misalign), 0);
    check_eq("rst_we", 32'(mem_we), 0);
    tick(); #1;
    check_eq("fetch0_stall", 32'(fetch_stall), 0);
    check_eq("fetch0_data", fetch_data, 32'hA000_0000);
    tick(); fetch_addr = 32'h4; #1;
    check_eq("fetch_data_m0", fetch_data, 32'hA000_0000);
    tick(); fetch_addr = 32'h8; #1;
    check_eq("fetch_data_m1", fetch_data, 32'hA000_0001);
    tick(); fetch_addr = 32'hC; #1;
    check_eq("fetch_data_m2", fetch_data, 32'hA000_0002);

    // Loader preemption with three writes.
    tick(); fetch_addr = 32'h10; ldr_req = 1; #1;
    check_eq("pre_drain_stall", 32'(fetch_stall), 0);
    check_eq("pre_drain_data", fetch_data, 32'hA000_0003);
    tick(); #1;
    check_eq("drain_stall", 32'(fetch_stall), 1);
    check_eq("drain_en", 32'(mem_en), 0);
    check_eq("drain_data", fetch_data, 32'hA000_0004);
    for (int k = 0; k < 3; k++) begin
      tick();
      ldr_valid = 1; ldr_addr = 32'h40 + 32'(k) * 4; ldr_wdata = 32'hCAFE_0000 + 32'(k);
      if (k == 2) ldr_req = 0;
      #1;
      check_eq("ldr_gnt", 32'(ldr_gnt), 1);
      check_eq("ldr_stall", 32'(fetch_stall), 1);
      check_eq("ldr_nop", fetch_data, NOP);
      check_eq("ldr_we", 32'(mem_we), 1);
      check_eq("ldr_maddr", 32'(mem_addr), 32'd16 + 32'(k));
    end
    tick(); ldr_valid = 0; #1;
    check_eq("resume_gnt", 32'(ldr_gnt), 0);
    check_eq("resume_stall", 32'(fetch_stall), 1);
    check_eq("resume_en", 32'(mem_en), 1);
    check_eq("resume_maddr", 32'(mem_addr), 32'd4);
    check_eq("count3", 32'(ldr_count), 3);
    tick(); #1;
    check_eq("refetch_stall", 32'(fetch_stall), 0);
    check_eq("refetch_data", fetch_data, 32'hA000_0004);
    fetch_addr = 32'h40;
    tick(); fetch_addr = 32'h44; #1;
    check_eq("written_w16", fetch_data, 32'hCAFE_0000);
    tick(); #1;
    check_eq("written_w17", fetch_data, 32'hCAFE_0001);

    // Out-of-range write.
    ldr_req = 1;
    tick(); tick();
    ldr_valid = 1; ldr_addr = 32'h1000; ldr_wdata = 32'hDEAD_BEEF; #1;
    check_eq("oor_gnt", 32'(ldr_gnt), 1);
    check_eq("oor_we", 32'(mem_we), 0);
    tick(); ldr_valid = 0; ldr_req = 0; #1;
    check_eq("oor_err", 32'(ldr_err), 1);
    check_eq("oor_count", 32'(ldr_count), 3);
    tick(); tick(); #1;
    check_eq("oor_err_sticky", 32'(ldr_err), 1);
    check_eq("oor_back_fetch", 32'(fetch_stall), 0);

    // 70-word stream against a 64-word burst limit.
    ldr_req = 1; ldr_valid = 1; set_word(0); #1;
    tick(); #1;
    check_eq("b_drain_gnt", 32'(ldr_gnt), 0);
    for (int k = 0; k < 64; k++) begin
      tick(); set_word(k); #1;
      check_eq("b1_gnt", 32'(ldr_gnt), 1);
    end
    tick(); set_word(64); #1;
    check_eq("b1_resume_gnt", 32'(ldr_gnt), 0);
    check_eq("b1_resume_we", 32'(mem_we), 0);
    check_eq("b1_count", 32'(ldr_count), 67);
    tick(); #1;
    check_eq("b_gap_stall", 32'(fetch_stall), 0);
    check_eq("b_gap_gnt", 32'(ldr_gnt), 0);
    tick(); #1;
    check_eq("b_drain2_stall", 32'(fetch_stall), 1);
    check_eq("b_drain2_gnt", 32'(ldr_gnt), 0);
    for (int k = 64; k < 70; k++) begin
      tick(); set_word(k);
      if (k == 69) ldr_req = 0;
      #1;
      check_eq("b2_gnt", 32'(ldr_gnt), 1);
    end
    tick(); ldr_valid = 0; #1;
    check_eq("b2_resume_gnt", 32'(ldr_gnt), 0);
    check_eq("b_count70", 32'(ldr_count), 73);
    tick(); fetch_addr = 32'h100 + 69 * 4;
    tick(); fetch_addr = 32'h100 + 63 * 4; #1;
    check_eq("b_word69", fetch_data, 32'h5000_0045);
    tick(); #1;
    check_eq("b_word63", fetch_data, 32'h5000_003F);

    // Reset during a loader burst.
    ldr_req = 1; ldr_valid = 1;
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      set_word(200 + k); #1;
      check_eq("rl_we", 32'(mem_we), 1);
      tick();
    end
    check_eq("rl_count", 32'(ldr_count), 75);
    set_word(202); reset = 1; #1;
    check_eq("rl_reset_we", 32'(mem_we), 0);
    tick(); reset = 0; ldr_req = 0; ldr_valid = 0; fetch_addr = 32'h0; #1;
    check_eq("rl_gnt", 32'(ldr_gnt), 0);
    check_eq("rl_count0", 32'(ldr_count), 0);
    check_eq("rl_err0", 32'(ldr_err), 0);
    check_eq("rl_stall", 32'(fetch_stall), 1);

    // Misaligned fetch.
    tick(); fetch_addr = 32'h6; #1;
    check_eq("mis_before", 32'(fetch_misalign), 0);
    tick(); fetch_addr = 32'h8; #1;
    check_eq("mis_pulse", 32'(fetch_misalign), 1);
    check_eq("mis_data", fetch_data, 32'hA000_0001);
    tick(); #1;
    check_eq("mis_clear", 32'(fetch_misalign), 0);
    check_eq("mis_next_data", fetch_data, 32'hA000_0002);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
